dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned LAT_CNT_W        = 4;
    localparam int unsigned WORD_OFFSET_BITS = 2;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, asynchronous read, never cleared.
module dmem_array #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: accepts one request, waits LATENCY cycles,
// then pulses ack_o with read data or a write acknowledge (err_o on bad address).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t                 state, state_nx;
    logic [LAT_CNT_W-1:0]   cnt, cnt_nx;
    logic                   cap_we;
    logic [ADDR_W-1:0]      cap_addr;
    logic [31:0]            cap_wdata;
    logic                   accept;
    logic                   misaligned;
    logic                   out_of_range;
    logic                   addr_err;
    logic                   arr_we;
    logic [31:0]            arr_rdata;

    assign ready_o = (state == IDLE);
    assign accept  = req_i && ready_o;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx   = LAT_CNT_W'(LATENCY - 1);
                    state_nx = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == LAT_CNT_W'(1)) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                cap_we    <= we_i;
                cap_addr  <= addr_i;
                cap_wdata <= wdata_i;
            end
        end
    end

    assign misaligned = |cap_addr[WORD_OFFSET_BITS-1:0];

    // Any address bit above the word index means the byte address is >= DEPTH*4.
    generate
        if (ADDR_W > IDX_W + WORD_OFFSET_BITS) begin : g_oor
            assign out_of_range = |cap_addr[ADDR_W-1:IDX_W+WORD_OFFSET_BITS];
        end else begin : g_no_oor
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign addr_err = misaligned | out_of_range;
    assign ack_o    = (state == RESP);
    assign busy_o   = (state != IDLE);
    assign err_o    = ack_o && addr_err;

    // Write lands on the edge ending RESP; a reset on that edge aborts it.
    assign arr_we  = ack_o && cap_we && !addr_err && !rst_i;
    assign rdata_o = (ack_o && !cap_we && !addr_err) ? arr_rdata : '0;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .idx_i   (cap_addr[IDX_W+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS]),
        .wdata_i (cap_wdata),
        .rdata_o (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: LATENCY=3 instance for the main tests,
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic        ready, ack, err, busy;
    logic [31:0] rdata;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic        ready1, ack1, err1, busy1;
    logic [31:0] rdata1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(3), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .ready_o(ready), .ack_o(ack), .rdata_o(rdata),
        .err_o(err), .busy_o(busy)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(1), .ADDR_W(32)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .wdata_i(wdata1), .ready_o(ready1), .ack_o(ack1), .rdata_o(rdata1),
        .err_o(err1), .busy_o(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the LATENCY=3 instance; inputs are scrambled after acceptance.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        req = 1'b1; we = w; addr = a; wdata = d;
        step();
        req = 1'b0; we = ~w; addr = a ^ 32'h4; wdata = ~d;
        lat = -1; rd = 32'hxxxxxxxx; er = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            if (ack) begin
                rd = rdata; er = err; lat = c;
                break;
            end
            step();
        end
        step();
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [7:0]  ack_pat;
    logic        any_ack;

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; } op_t;
    op_t ops[4];

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        step(); step();
        rst = 1'b0;

        check("rst_ready", ready, 1);
        check("rst_ack",   ack,   0);
        check("rst_busy",  busy,  0);
        check("rst_rdata", rdata, 0);
        check("rst_err",   err,   0);

        // Test 1: store 0x10 with per-cycle timing checks
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;
        step();
        req = 1'b0; we = 1'b0; addr = 32'h14; wdata = '0;
        check("t1_c1_busy", busy, 1); check("t1_c1_ack", ack, 0); check("t1_c1_ready", ready, 0);
        step();
        check("t1_c2_busy", busy, 1); check("t1_c2_ack", ack, 0);
        step();
        check("t1_c3_ack", ack, 1); check("t1_c3_err", err, 0);
        check("t1_c3_busy", busy, 1); check("t1_c3_ready", ready, 0);
        step();
        check("t1_c4_ready", ready, 1); check("t1_c4_busy", busy, 0); check("t1_c4_ack", ack, 0);

        // Test 2: load back with address mutated after acceptance
        xact(1'b0, 32'h10, 32'h0, rd, er, lat);
        check("t2_lat", lat, 3); check("t2_rdata", rd, 32'hDEADBEEF); check("t2_err", er, 0);

        // Test 3: misaligned load and store
        xact(1'b0, 32'h12, 32'h0, rd, er, lat);
        check("t3_ld_lat", lat, 3); check("t3_ld_err", er, 1); check("t3_ld_rdata", rd, 0);
        xact(1'b1, 32'h11, 32'h1, rd, er, lat);
        check("t3_st_lat", lat, 3); check("t3_st_err", er, 1);
        xact(1'b0, 32'h10, 32'h0, rd, er, lat);
        check("t3_reload", rd, 32'hDEADBEEF);

        // Test 4: out-of-range store aliases word 0 and must not write it
        xact(1'b1, 32'h0, 32'h0BADC0DE, rd, er, lat);
        check("t4_pre_err", er, 0);
        xact(1'b1, 32'h1000, 32'hCAFEF00D, rd, er, lat);
        check("t4_oor_lat", lat, 3); check("t4_oor_err", er, 1);
        xact(1'b0, 32'h0, 32'h0, rd, er, lat);
        check("t4_word0", rd, 32'h0BADC0DE);

        // Test 4b: req held high through WAIT -> second accept only at cycle 4
        req = 1'b1; we = 1'b0; addr = 32'h10; wdata = '0;
        step();
        ack_pat = '0;
        for (int c = 1; c <= 7; c++) begin
            ack_pat[c] = ack;
            if (c <= 3) check("t4_held_ready", ready, 0);
            if (c == 3) check("t4_held_rdata", rdata, 32'hDEADBEEF);
            if (c == 5) req = 1'b0;
            step();
        end
        check("t4_held_ackpat", ack_pat, 8'b1000_1000);
        check("t4_held_idle", ready, 1);

        // Test 5: reset during WAIT aborts the store
        xact(1'b1, 32'h20, 32'h11111111, rd, er, lat);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
        step();
        req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_ready", ready, 1); check("t5_busy", busy, 0); check("t5_ack", ack, 0);
        any_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            any_ack |= ack;
            step();
        end
        check("t5_no_ack", any_ack, 0);
        xact(1'b0, 32'h20, 32'h0, rd, er, lat);
        check("t5_unwritten", rd, 32'h11111111);

        // Test 5b: reset on the edge ending RESP aborts the store
        xact(1'b1, 32'h24, 32'h22222222, rd, er, lat);
        req = 1'b1; we = 1'b1; addr = 32'h24; wdata = 32'h33333333;
        step();
        req = 1'b0;
        step(); step();
        check("t5b_in_resp", ack, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5b_ready", ready, 1);
        xact(1'b0, 32'h24, 32'h0, rd, er, lat);
        check("t5b_unwritten", rd, 32'h22222222);

        // Test 6: LATENCY=1, request held high, junk stores presented in RESP cycles
        ops[0] = '{1'b1, 32'h40, 32'hA5A5A5A5};
        ops[1] = '{1'b1, 32'h44, 32'h5A5A5A5A};
        ops[2] = '{1'b0, 32'h40, 32'h0};
        ops[3] = '{1'b0, 32'h44, 32'h0};
        req1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check("t6_ack",   ack1,   (c % 2 == 1) ? 1 : 0);
            check("t6_ready", ready1, (c % 2 == 0) ? 1 : 0);
            if (c == 5) check("t6_rdata40", rdata1, 32'hA5A5A5A5);
            if (c == 7) check("t6_rdata44", rdata1, 32'h5A5A5A5A);
            if (c % 2 == 0) begin
                we1 = ops[c/2].w; addr1 = ops[c/2].a; wdata1 = ops[c/2].d;
            end else begin
                we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'hFFFFFFFF;
            end
            if (c == 7) req1 = 1'b0;
            step();
        end
        check("t6_idle", ready1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
